// File: rtl/root8_stream_pkg.sv
// Shared types and derived constants for the root8_stream eighth-root block.
// Also used by the bench so that latency and widths come from one place.
package root8_stream_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned NumPasses = 3;
    localparam int unsigned DefaultDw = 64;

    function automatic int unsigned root_width(input int unsigned dw);
        return dw / 8;
    endfunction

    // Pass p consumes a (dw >> p)-bit operand, one root bit per iteration.
    function automatic int unsigned pass_iters(input int unsigned dw, input int unsigned pass);
        return (dw >> pass) / 2;
    endfunction

    function automatic int unsigned total_latency(input int unsigned dw);
        return 7 * dw / 8;
    endfunction

    localparam int unsigned DefaultRw      = root_width(DefaultDw);
    localparam int unsigned DefaultLatency = total_latency(DefaultDw);

endpackage

// File: rtl/root8_stream_isqrt_step.sv
// One restoring digit-by-digit square-root iteration: brings in two operand bits,
// produces one root bit. Purely combinational.
module isqrt_step #(
    parameter int unsigned RemW  = 34,
    parameter int unsigned RootW = RemW - 2
) (
    input  logic [RemW-1:0]  rem,
    input  logic [RootW-1:0] root,
    input  logic [1:0]       bits,
    output logic [RemW-1:0]  rem_next,
    output logic [RootW-1:0] root_next
);

    logic [RemW+1:0] shifted;
    logic [RemW+1:0] trial;
    logic            fits;

    // Evaluated two bits wider than the register; the remainder bound keeps the top bits zero.
    always_comb begin
        shifted   = {rem, bits};
        trial     = {2'b00, root, 2'b01};
        fits      = (shifted >= trial);
        rem_next  = fits ? RemW'(shifted - trial) : RemW'(shifted);
        root_next = RootW'({root, fits});
    end

endmodule

// File: rtl/root8_stream.sv
// floor(x^(1/8)) over valid/ready streams via three chained iterative square roots
// (DW -> DW/2 -> DW/4 -> DW/8 bits); one operation in flight.
module root8_stream
    import root8_stream_pkg::*;
#(
    parameter int unsigned DW = 64,
    parameter int unsigned RW = root_width(DW)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [RW-1:0] m_data
);

    localparam int unsigned RemW  = DW / 2 + 2;
    localparam int unsigned RootW = DW / 2;
    localparam int unsigned IterW = $clog2(DW / 2);

    localparam logic [IterW-1:0] LastIter0 = IterW'(pass_iters(DW, 0) - 1);
    localparam logic [IterW-1:0] LastIter1 = IterW'(pass_iters(DW, 1) - 1);
    localparam logic [IterW-1:0] LastIter2 = IterW'(pass_iters(DW, 2) - 1);

    state_e           state_q, state_d;
    logic [1:0]       pass_q, pass_d;
    logic [IterW-1:0] iter_q, iter_d;
    logic [DW-1:0]    op_q, op_d;
    logic [RemW-1:0]  rem_q, rem_d, rem_step;
    logic [RootW-1:0] root_q, root_d, root_step;
    logic [RW-1:0]    m_data_q, m_data_d;
    logic             iter_last;

    isqrt_step #(
        .RemW  (RemW),
        .RootW (RootW)
    ) u_step (
        .rem       (rem_q),
        .root      (root_q),
        .bits      (op_q[DW-1 -: 2]),
        .rem_next  (rem_step),
        .root_next (root_step)
    );

    always_comb begin
        unique case (pass_q)
            2'd0:    iter_last = (iter_q == LastIter0);
            2'd1:    iter_last = (iter_q == LastIter1);
            default: iter_last = (iter_q == LastIter2);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pass_d   = pass_q;
        iter_d   = iter_q;
        op_d     = op_q;
        rem_d    = rem_q;
        root_d   = root_q;
        m_data_d = m_data_q;

        unique case (state_q)
            StIdle: begin
                if (s_valid) begin
                    op_d    = s_data;
                    rem_d   = '0;
                    root_d  = '0;
                    pass_d  = 2'd0;
                    iter_d  = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                op_d   = op_q << 2;
                rem_d  = rem_step;
                root_d = root_step;
                iter_d = iter_q + IterW'(1);
                if (iter_last) begin
                    rem_d  = '0;
                    root_d = '0;
                    iter_d = '0;
                    if (pass_q == 2'd2) begin
                        pass_d   = 2'd0;
                        m_data_d = root_step[RW-1:0];
                        state_d  = StDone;
                    end else begin
                        pass_d = pass_q + 2'd1;
                        // Next operand is this pass's root, MSB-aligned in the shift register.
                        if (pass_q == 2'd0) begin
                            op_d = {root_step, {(DW - RootW){1'b0}}};
                        end else begin
                            op_d = {root_step[DW/4-1:0], {(DW - DW/4){1'b0}}};
                        end
                    end
                end
            end
            StDone: begin
                if (m_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            pass_q   <= 2'd0;
            iter_q   <= '0;
            op_q     <= '0;
            rem_q    <= '0;
            root_q   <= '0;
            m_data_q <= '0;
        end else begin
            state_q  <= state_d;
            pass_q   <= pass_d;
            iter_q   <= iter_d;
            op_q     <= op_d;
            rem_q    <= rem_d;
            root_q   <= root_d;
            m_data_q <= m_data_d;
        end
    end

    assign s_ready = (state_q == StIdle);
    assign m_valid = (state_q == StDone);
    assign m_data  = m_data_q;

endmodule

// File: tb/tb_root8_stream.sv
// Directed and randomized stream checks for root8_stream against an independent
// brute-force eighth-root reference.
module tb_root8_stream;
    import root8_stream_pkg::*;

    localparam int unsigned DW  = DefaultDw;
    localparam int unsigned RW  = DefaultRw;
    localparam int unsigned LAT = DefaultLatency;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [RW-1:0] m_data;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    root8_stream #(
        .DW (DW)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] root8_ref(input logic [63:0] x);
        logic [127:0] p;
        logic [63:0]  r;
        r = 0;
        for (int c = 1; c < 256; c++) begin
            p = 128'd1;
            for (int k = 0; k < 8; k++) p = p * 128'(c);
            if (p <= {64'd0, x}) r = 64'(c);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Returns positioned just after the accepting edge.
    task automatic send(input logic [63:0] x);
        int n;
        n = 0;
        s_data  = x;
        s_valid = 1'b1;
        while (!s_ready && n < 200) begin
            cyc();
            n++;
        end
        check("send_ready", 64'(s_ready), 64'd1);
        cyc();
        s_valid = 1'b0;
    endtask

    task automatic get(input string tag, input logic [63:0] exp, input bit chk_lat);
        int n;
        n = 0;
        while (!m_valid && n < 200) begin
            cyc();
            n++;
        end
        check({tag, "_valid"}, 64'(m_valid), 64'd1);
        if (chk_lat) check({tag, "_lat"}, 64'(n), 64'(LAT));
        check(tag, 64'(m_data), exp);
        m_ready = 1'b1;
        cyc();
        check({tag, "_sready"}, 64'(s_ready), 64'd1);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            cyc();
            if (m_valid) seen++;
        end
        check(tag, 64'(seen), 64'd0);
        check({tag, "_sready"}, 64'(s_ready), 64'd1);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        rstn = 1'b1;
        cyc();
        m_ready = 1'b1;

        send(64'd0);          get("x0", 64'd0, 1'b1);
        send(64'd1);          get("x1", 64'd1, 1'b1);
        send(64'd255);        get("x255", 64'd1, 1'b1);
        send(64'd256);        get("x256", 64'd2, 1'b1);
        send(64'd6560);       get("x6560", 64'd2, 1'b1);
        send(64'd6561);       get("x3p8", 64'd3, 1'b1);
        send(64'd5764801);    get("x7p8", 64'd7, 1'b1);
        send({64{1'b1}});     get("xmax", 64'd255, 1'b1);

        // Backpressure: result must hold while m_ready is low.
        m_ready = 1'b0;
        send(64'd256);
        n = 0;
        while (!m_valid && n < 200) begin
            cyc();
            n++;
        end
        check("hold_lat", 64'(n), 64'(LAT));
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("hold_valid", 64'(m_valid), 64'd1);
            check("hold_data", 64'(m_data), 64'd2);
            check("hold_sready", 64'(s_ready), 64'd0);
        end
        m_ready = 1'b1;
        cyc();
        check("hold_done_sready", 64'(s_ready), 64'd1);
        check("hold_done_valid", 64'(m_valid), 64'd0);

        // s_valid pulse while busy must be dropped.
        send(64'd256);
        repeat (10) cyc();
        s_data  = 64'd6561;
        s_valid = 1'b1;
        cyc();
        s_valid = 1'b0;
        get("pulse", 64'd2, 1'b0);
        quiet("pulse_none", 70);

        // Reset mid-calculation abandons the operation.
        send(64'd6561);
        repeat (20) cyc();
        rstn = 1'b0;
        repeat (2) cyc();
        rstn = 1'b1;
        check("rst_mid_valid", 64'(m_valid), 64'd0);
        check("rst_mid_sready", 64'(s_ready), 64'd1);
        quiet("rst_mid_none", 70);
        send(64'd5764801);
        get("post_rst", 64'd7, 1'b1);

        // Random stream with random output backpressure.
        fork
            begin
                logic [63:0] x;
                int w;
                for (int i = 0; i < 200; i++) begin
                    x = {$urandom, $urandom} >> $urandom_range(0, 63);
                    s_data  = x;
                    s_valid = 1'b1;
                    w = 0;
                    do begin
                        @(negedge clk);
                        w++;
                    end while (!s_ready && w < 400);
                    if (!s_ready) begin
                        check("rand_accept", 64'(s_ready), 64'd1);
                        break;
                    end
                    exp_q.push_back(root8_ref(x));
                    @(posedge clk);
                    #1;
                end
                s_valid = 1'b0;
            end
            begin
                int got;
                int cycles;
                logic [63:0] e;
                got = 0;
                cycles = 0;
                while (got < 200 && cycles < 30000) begin
                    @(posedge clk);
                    #1;
                    m_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    cycles++;
                    if (m_valid && m_ready) begin
                        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD;
                        check("rand_out", 64'(m_data), e);
                        got++;
                    end
                end
                check("rand_count", 64'(got), 64'd200);
                m_ready = 1'b1;
            end
        join
        check("rand_leftover", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/root8_stream.md
Name: root8_stream

Overview:
- Stream-side inverse of the team's 8th-power pipeline: consumes a 64-bit valid/ready stream and returns floor(x^(1/8)) on an 8-bit valid/ready stream.
- Computes the result with three chained integer square roots: 64->32, 32->16, 16->8 bits. Each square root uses a digit-by-digit (restoring, one root bit per cycle) method.
- Sits on the far end of the power-pipeline output. Used for round-trip checking and for magnitude reduction ahead of downstream consumers.
- Iterative, single operation in flight. Low area, long latency.

Parameters:
- DW, 64, input radicand width; must be a multiple of 8, minimum 16.
- RW, DW/8, output root width; derived value, must not be overridden.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- s_valid  in  1  input beat valid
- s_ready  out  1  block can accept a beat
- s_data  in  DW  unsigned radicand
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result
- m_data  out  RW  unsigned root, floor(s_data^(1/8))

Behaviour:
- Reset is rstn, asynchronous, active-low; clock is clk. All state clears on reset.
  - Reset values: s_ready=1, m_valid=0, m_data=0, FSM=IDLE, pass counter=0, iteration counter=0, remainder=0, work registers=0.
- FSM states: IDLE, CALC, DONE.
  - IDLE: s_ready=1. On s_valid&&s_ready, latch s_data as radicand and clear the root and remainder. Set pass=0, iter=0, go to CALC.
  - CALC: s_ready=0, m_valid=0.
    - Pass p (0,1,2) has operand width W_p = DW>>p and runs W_p/2 iterations.
    - Each iteration (restoring):
      - rem' = (rem<<2) | next 2 MSBs of the operand;
      - trial = (root<<2)|1;
      - if rem' >= trial then rem=rem'-trial, root=(root<<1)|1;
      - else rem=rem', root=root<<1.
    - At the end of pass p, root (W_p/2 bits) becomes the operand of pass p+1. Remainder and root are cleared for the next pass.
    - After the last iteration of pass 2, load m_data with the root, set m_valid=1, go to DONE.
  - DONE: m_valid=1, s_ready=0, m_data held stable. On m_valid&&m_ready, clear m_valid at that edge and go to IDLE.
- Latency: handshake at edge k, then DW/2+DW/4+DW/8 = 7*DW/8 CALC cycles (56 for DW=64). m_valid is high after edge k+56.
- Throughput: one result per 58 cycles minimum (accept, 56 calc, output handshake). The next s_ready=1 is the cycle after the output handshake.
- Handshake rules:
  - s_valid while busy is ignored. No data is captured and the source is not required to hold the beat.
  - m_data and m_valid never change while m_valid=1 && m_ready=0.
  - m_ready while not in DONE has no effect.
- Arithmetic:
  - Remainder register width is DW/2+2 bits, which covers pass 0.
  - All comparisons are unsigned.
  - The nested floor-sqrt result equals floor(x^(1/8)) exactly. x=2^DW-1 yields 2^RW-1 with no overflow.
- Boundary conditions:
  - x=0 yields 0.
  - Exact 8th powers yield the exact root.
  - Pass and iteration counters wrap to 0 at pass end.
- Reset mid-operation (CALC or DONE) abandons the operation. No output beat is produced, and the block returns to IDLE with s_ready=1 after rstn deasserts.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE/CALC/DONE, 2-bit);
  - the derived constants RW, the per-pass iteration counts and the total latency (7*DW/8), so the bench uses the same numbers.
- One natural sub-module, isqrt_step: a combinational single-iteration block. Inputs are rem, root and the 2 operand bits; outputs are next rem and next root.
- The FSM, counters and operand shift register stay in root8_stream.

Test Plan:
- Reset, then x=0, 1, 255, 256 with m_ready=1. Expected results are 0, 1, 1, 2, each with m_valid rising exactly 56 cycles after its accept edge.
- x=6560, 6561 (3^8), 5764801 (7^8), 2^64-1. Expected results are 2, 3, 7, 255.
- Accept x=256 with m_ready held 0 for 10 cycles after m_valid rises. m_valid stays 1, m_data=2 is stable and s_ready=0 throughout. When m_ready=1 the handshake completes and s_ready=1 on the next cycle.
- Pulse s_valid with x=6561 during CALC of x=256. The pulse is ignored: one result (2) only, and the next accept happens only when s_ready=1.
- Assert rstn=0 for 2 cycles midway through CALC. m_valid stays 0 and s_ready=1 after release. A fresh x=5764801 then yields 7 with full 56-cycle latency.
- Random back-to-back stream of 200 values with random m_ready gaps. Each output equals the reference model floor(x^(1/8)), in order, with no drops or duplicates.
